rom_fetch_sequencer: RTL and testbench

- Controller between the microprocessor core's program counter and the slow instruction ROM.
- Accepts a fetch request with an address and holds the ROM address stable for a fixed number of wait-state cycles.
- Captures the ROM data into an instruction register, pulses a valid strobe, and stalls the core for the whole fetch.
- Supports abort/restart on a core flush (jump/branch), so a fetch from a stale PC never delivers an instruction.

---
 rtl/rom_fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_rom_fetch_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_sequencer.sv
// rom_fetch_sequencer
//   Sits between the core's program counter and a slow instruction ROM.
//   A fetch request latches the PC onto the ROM address bus and holds it
//   for WAIT_STATES cycles. The ROM word is then captured into the
//   instruction register and ir_valid pulses for one cycle. A flush
//   (taken jump/branch) kills the in-flight fetch. If fetch_req arrives
//   in the same cycle as the flush, the fetch restarts at the new PC.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   fetch_req in   core requests an instruction at pc_in
//   pc_in     in   fetch address from the core PC
//   flush     in   abort the in-flight fetch
//   rom_addr  out  registered ROM address
//   rom_data  in   ROM read data, valid WAIT_STATES cycles after rom_addr changes
//   ir_out    out  registered captured instruction
//   ir_valid  out  one-cycle pulse when ir_out holds a new instruction
//   stall     out  combinational: core must hold PC and pipeline
//   busy      out  registered, high while a fetch is outstanding

module rom_fetch_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              flush,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] ir_out,
   output logic              ir_valid,
   output logic              stall,
   output logic              busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // The count reaches zero in the last wait cycle, so the capture edge
   // falls exactly WAIT_STATES edges after the acceptance edge.
   localparam logic [3:0] CNT_RELOAD = 4'(WAIT_STATES - 1);

   state_t     state_r;
   logic [3:0] cnt_r;
   logic       ir_valid_next_s;

   // Capture qualifier: last wait cycle with no flush pending.
   always_comb begin
      ir_valid_next_s = 1'b0;
      if ((state_r == ST_WAIT) && !flush && (cnt_r == 4'd0)) begin
         ir_valid_next_s = 1'b1;
      end else begin
         ir_valid_next_s = 1'b0;
      end
   end

   // Stall covers the whole fetch. It also covers the IDLE cycle in which
   // a new request is being accepted.
   always_comb begin
      stall = 1'b0;
      if (state_r == ST_WAIT) begin
         stall = 1'b1;
      end else begin
         stall = fetch_req & ~ir_valid_next_s;
      end
   end

   // Fetch state machine with registered ROM address, instruction register,
   // valid strobe and busy flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 4'd0;
         rom_addr <= {ADDR_W{1'b0}};
         ir_out   <= {DATA_W{1'b0}};
         ir_valid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         ir_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (fetch_req) begin
                  rom_addr <= pc_in;
                  cnt_r    <= CNT_RELOAD;
                  state_r  <= ST_WAIT;
                  busy     <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (flush) begin
                  // A flush paired with a request redirects the fetch
                  // instead of dropping back to IDLE.
                  if (fetch_req) begin
                     rom_addr <= pc_in;
                     cnt_r    <= CNT_RELOAD;
                  end else begin
                     state_r <= ST_IDLE;
                     busy    <= 1'b0;
                  end
               end else if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end else begin
                  ir_out   <= rom_data;
                  ir_valid <= 1'b1;
                  state_r  <= ST_IDLE;
                  busy     <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
module tb_rom_fetch_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;

   // Instance 0: WAIT_STATES = 2
   logic       fetch_req = 1'b0;
   logic [7:0] pc_in = 8'h00;
   logic       flush = 1'b0;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] ir_out;
   logic       ir_valid;
   logic       stall;
   logic       busy;

   // Instance 1: WAIT_STATES = 1
   logic       fetch_req1 = 1'b0;
   logic [7:0] pc_in1 = 8'h00;
   logic       flush1 = 1'b0;
   logic [7:0] rom_addr1;
   logic [7:0] rom_data1;
   logic [7:0] ir_out1;
   logic       ir_valid1;
   logic       stall1;
   logic       busy1;

   int errors = 0;
   int checks = 0;

   rom_fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(2)) dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_in(pc_in),
      .flush(flush), .rom_addr(rom_addr), .rom_data(rom_data),
      .ir_out(ir_out), .ir_valid(ir_valid), .stall(stall), .busy(busy)
   );

   rom_fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(1)) dut1 (
      .clk(clk), .reset(reset), .fetch_req(fetch_req1), .pc_in(pc_in1),
      .flush(flush1), .rom_addr(rom_addr1), .rom_data(rom_data1),
      .ir_out(ir_out1), .ir_valid(ir_valid1), .stall(stall1), .busy(busy1)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_fn(input logic [7:0] a);
      return a ^ 8'hA0;
   endfunction

   // Slow ROM models: the data is garbage (8'hEE) until the address has
   // been stable for the instance's wait-state count.
   int         age0 = 0;
   logic [7:0] last0 = 8'h00;
   int         age1 = 0;
   logic [7:0] last1 = 8'h00;

   always @(negedge clk) begin
      if (rom_addr != last0) begin
         last0 <= rom_addr;
         age0  <= 1;
      end else if (age0 < 15) begin
         age0 <= age0 + 1;
      end
      if (rom_addr1 != last1) begin
         last1 <= rom_addr1;
         age1  <= 1;
      end else if (age1 < 15) begin
         age1 <= age1 + 1;
      end
   end

   assign rom_data  = (age0 >= 2) ? rom_fn(rom_addr)  : 8'hEE;
   assign rom_data1 = (age1 >= 1) ? rom_fn(rom_addr1) : 8'hEE;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks += 5;
         if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr cyc%0d: got %h want 00", i, rom_addr); end
         if (ir_out !== 8'h00) begin errors++; $display("FAIL reset_ir_out cyc%0d: got %h want 00", i, ir_out); end
         if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid cyc%0d: got %b want 0", i, ir_valid); end
         if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall cyc%0d: got %b want 0", i, stall); end
         if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d: got %b want 0", i, busy); end
      end
   endtask

   task automatic test_single_fetch();
      fetch_req = 1'b1; pc_in = 8'h05; #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL single_accept_stall: got %b want 1", stall); end
      step();                       // edge 0: accept
      fetch_req = 1'b0; pc_in = 8'h77; #1;
      checks += 4;
      if (rom_addr !== 8'h05) begin errors++; $display("FAIL single_rom_addr: got %h want 05", rom_addr); end
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy0: got %b want 1", busy); end
      if (stall !== 1'b1) begin errors++; $display("FAIL single_stall0: got %b want 1", stall); end
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL single_valid0: got %b want 0", ir_valid); end
      step();                       // edge 1
      checks += 3;
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL single_valid1: got %b want 0", ir_valid); end
      if (stall !== 1'b1) begin errors++; $display("FAIL single_stall1: got %b want 1", stall); end
      if (rom_addr !== 8'h05) begin errors++; $display("FAIL single_addr_hold: got %h want 05", rom_addr); end
      step();                       // edge 2: capture
      checks += 4;
      if (ir_valid !== 1'b1) begin errors++; $display("FAIL single_valid2: got %b want 1", ir_valid); end
      if (ir_out !== 8'hA5) begin errors++; $display("FAIL single_ir_out: got %h want a5", ir_out); end
      if (stall !== 1'b0) begin errors++; $display("FAIL single_stall2: got %b want 0", stall); end
      if (busy !== 1'b0) begin errors++; $display("FAIL single_busy2: got %b want 0", busy); end
      step();
      checks += 2;
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL single_valid3: got %b want 0", ir_valid); end
      if (ir_out !== 8'hA5) begin errors++; $display("FAIL single_ir_hold: got %h want a5", ir_out); end
   endtask

   task automatic test_back_to_back();
      fetch_req = 1'b1; pc_in = 8'h00;
      for (int i = 0; i < 3; i++) begin
         step();                    // acceptance edge
         checks += 2;
         if (rom_addr !== 8'(i)) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", i, rom_addr, 8'(i)); end
         if (ir_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_a%0d: got %b want 0", i, ir_valid); end
         step();
         checks += 2;
         if (ir_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_b%0d: got %b want 0", i, ir_valid); end
         if (rom_addr !== 8'(i)) begin errors++; $display("FAIL b2b_addr_hold%0d: got %h want %h", i, rom_addr, 8'(i)); end
         step();                    // capture edge
         checks += 2;
         if (ir_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_c%0d: got %b want 1", i, ir_valid); end
         if (ir_out !== rom_fn(8'(i))) begin errors++; $display("FAIL b2b_ir%0d: got %h want %h", i, ir_out, rom_fn(8'(i))); end
         if (i < 2) begin
            pc_in = 8'(i + 1); #1;
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall_reaccept%0d: got %b want 1", i, stall); end
         end else begin
            fetch_req = 1'b0; #1;
            checks++;
            if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_last: got %b want 0", stall); end
         end
      end
      step();
      checks += 2;
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_end: got %b want 0", ir_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_flush_restart();
      fetch_req = 1'b1; pc_in = 8'h10;
      step();                       // accept 0x10
      checks++;
      if (rom_addr !== 8'h10) begin errors++; $display("FAIL flushr_addr10: got %h want 10", rom_addr); end
      flush = 1'b1; pc_in = 8'h40;
      step();                       // flush + restart edge
      flush = 1'b0; fetch_req = 1'b0;
      checks += 3;
      if (rom_addr !== 8'h40) begin errors++; $display("FAIL flushr_addr40: got %h want 40", rom_addr); end
      if (busy !== 1'b1) begin errors++; $display("FAIL flushr_busy: got %b want 1", busy); end
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL flushr_valid0: got %b want 0", ir_valid); end
      step();
      checks++;
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL flushr_valid1: got %b want 0", ir_valid); end
      step();
      checks += 2;
      if (ir_valid !== 1'b1) begin errors++; $display("FAIL flushr_valid2: got %b want 1", ir_valid); end
      if (ir_out !== 8'hE0) begin errors++; $display("FAIL flushr_ir: got %h want e0", ir_out); end
      step();
      checks++;
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL flushr_valid3: got %b want 0", ir_valid); end
   endtask

   task automatic test_flush_capture();
      fetch_req = 1'b1; pc_in = 8'h22;
      step();                       // accept
      fetch_req = 1'b0;
      step();                       // now in the capture cycle
      flush = 1'b1; #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL flushc_stall_pre: got %b want 1", stall); end
      step();                       // capture edge, flush wins
      flush = 1'b0; #1;
      checks += 4;
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL flushc_valid: got %b want 0", ir_valid); end
      if (ir_out !== 8'hE0) begin errors++; $display("FAIL flushc_ir_keep: got %h want e0", ir_out); end
      if (busy !== 1'b0) begin errors++; $display("FAIL flushc_busy: got %b want 0", busy); end
      if (stall !== 1'b0) begin errors++; $display("FAIL flushc_stall: got %b want 0", stall); end
      step();
      checks++;
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL flushc_valid_late: got %b want 0", ir_valid); end
      // flush while IDLE without a request changes nothing
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks += 3;
      if (rom_addr !== 8'h22) begin errors++; $display("FAIL flushi_addr: got %h want 22", rom_addr); end
      if (busy !== 1'b0) begin errors++; $display("FAIL flushi_busy: got %b want 0", busy); end
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL flushi_valid: got %b want 0", ir_valid); end
   endtask

   task automatic test_reset_midwait();
      fetch_req = 1'b1; pc_in = 8'h33;
      step();
      fetch_req = 1'b0;
      step();                       // next edge would capture
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks += 4;
      if (rom_addr !== 8'h00) begin errors++; $display("FAIL rstw_addr: got %h want 00", rom_addr); end
      if (ir_out !== 8'h00) begin errors++; $display("FAIL rstw_ir: got %h want 00", ir_out); end
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL rstw_valid: got %b want 0", ir_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %b want 0", busy); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks += 2;
         if (ir_valid !== 1'b0) begin errors++; $display("FAIL rstw_valid_after%0d: got %b want 0", i, ir_valid); end
         if (stall !== 1'b0) begin errors++; $display("FAIL rstw_stall_after%0d: got %b want 0", i, stall); end
      end
   endtask

   task automatic test_wrap_ws1();
      fetch_req1 = 1'b1; pc_in1 = 8'hFF; #1;
      checks++;
      if (stall1 !== 1'b1) begin errors++; $display("FAIL ws1_stall_accept: got %b want 1", stall1); end
      step();
      fetch_req1 = 1'b0; #1;
      checks += 4;
      if (rom_addr1 !== 8'hFF) begin errors++; $display("FAIL ws1_addr: got %h want ff", rom_addr1); end
      if (busy1 !== 1'b1) begin errors++; $display("FAIL ws1_busy: got %b want 1", busy1); end
      if (ir_valid1 !== 1'b0) begin errors++; $display("FAIL ws1_valid0: got %b want 0", ir_valid1); end
      if (stall1 !== 1'b1) begin errors++; $display("FAIL ws1_stall_wait: got %b want 1", stall1); end
      step();
      checks += 4;
      if (ir_valid1 !== 1'b1) begin errors++; $display("FAIL ws1_valid1: got %b want 1", ir_valid1); end
      if (ir_out1 !== 8'h5F) begin errors++; $display("FAIL ws1_ir: got %h want 5f", ir_out1); end
      if (busy1 !== 1'b0) begin errors++; $display("FAIL ws1_busy_end: got %b want 0", busy1); end
      if (stall1 !== 1'b0) begin errors++; $display("FAIL ws1_stall_end: got %b want 0", stall1); end
      step();
      checks++;
      if (ir_valid1 !== 1'b0) begin errors++; $display("FAIL ws1_valid2: got %b want 0", ir_valid1); end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_flush_restart();
      test_flush_capture();
      test_reset_midwait();
      test_wrap_ws1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
